// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the dual-clock FIFO.
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default word and address widths
//   bin2gray / gray2bin                     : pointer encoding helpers, used by
//                                             both the write and read sides
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

  // Helpers operate on a 32-bit container. Callers zero-extend the pointer
  // and truncate the result. This is exact for Gray encoding because each
  // output bit depends only on the same and the next-higher input bit.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered priority pointer.
//   wclk, wrst : clock, asynchronous active-high reset
//   req        : per-requester request (level)
//   en         : allow a grant this cycle (gnt forced to zero when low)
//   upd        : advance the priority pointer past the granted index at the edge
//   gnt        : one-hot grant, combinational
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         upd,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_ptr_next;
  logic [PW-1:0] gidx;
  logic [PW:0]   sum;
  logic          found;

  // Walk the requesters starting at rr_ptr, wrapping modulo N; the first set
  // request wins. The sum carries one extra bit so the wrap test is exact.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    sum   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      if (!found && req[sum[PW-1:0]]) begin
        found = 1'b1;
        gidx  = sum[PW-1:0];
      end
    end
    if (found && en && !wrst) begin
      gnt[gidx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_next = (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      rr_ptr <= '0;
    end else if (upd && (|gnt)) begin
      rr_ptr <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: write-side controller for the shared FIFO memory.
// Round-robin arbitrates NUM_REQ writers onto the single memory write port
// (one word per wclk), and owns the binary/Gray write pointer and the
// registered full flag computed against the synchronized read Gray pointer.
//   wclk, wrst : write clock, asynchronous active-high reset
//   req        : per-requester write request, held until granted
//   req_data   : packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt        : one-hot grant; the word is accepted at this wclk edge
//   wq2_rptr   : read Gray pointer already synchronized into wclk
//   wdata      : memory write data (granted requester's slice)
//   waddr      : memory write address
//   wclken     : memory write enable
//   wfull      : registered full flag
//   wptr       : registered write Gray pointer for the read-side synchronizer
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic [ADDR_WIDTH:0]           wq2_rptr,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic                          wclken,
  output logic                          wfull,
  output logic [ADDR_WIDTH:0]           wptr
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] rptr_full_cmp;
  logic                wfull_next;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .wclk (wclk),
    .wrst (wrst),
    .req  (req),
    .en   (!wfull),
    .upd  (1'b1),
    .gnt  (gnt)
  );

  assign wclken = |gnt;
  assign waddr  = wbin[ADDR_WIDTH-1:0];

  always_comb begin
    wdata = req_data[DATA_WIDTH-1:0];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Full when the next write pointer equals the read pointer with its two
  // MSBs inverted: one lap ahead in Gray space.
  always_comb begin
    wbin_next     = wbin + {{ADDR_WIDTH{1'b0}}, wclken};
    wgray_next    = PTR_W'(bin2gray(32'(wbin_next)));
    rptr_full_cmp = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
    wfull_next    = (wgray_next == rptr_full_cmp);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin  <= '0;
      wptr  <= '0;
      wfull <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wptr  <= wgray_next;
      wfull <= wfull_next;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side controller for the shared FIFO memory.
- Round-robin arbitrates NUM_REQ writers onto the single memory write port, one accepted word per cycle.
- Owns the write pointer (binary and Gray) and the registered full flag, computed against the synchronized read Gray pointer.
- Sits in the write clock domain, directly in front of the FIFO memory.

Parameters:
DATA_WIDTH  8  word width of each requester and of the memory
ADDR_WIDTH  4  memory address width; depth = 2**ADDR_WIDTH
NUM_REQ     4  number of write requesters (2..8)

Ports:
wclk        input   1                        write clock
wrst        input   1                        reset, asynchronous, active-high
req         input   NUM_REQ                  per-requester write request, level, held until granted
req_data    input   NUM_REQ*DATA_WIDTH       packed data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
gnt         output  NUM_REQ                  one-hot grant; word accepted at this wclk edge
wq2_rptr    input   ADDR_WIDTH+1             read Gray pointer, already synchronized into wclk
wdata       output  DATA_WIDTH               to memory write data
waddr       output  ADDR_WIDTH               to memory write address = wbin[ADDR_WIDTH-1:0]
wclken      output  1                        to memory write enable = |gnt
wfull       output  1                        registered full flag (also fed to memory)
wptr        output  ADDR_WIDTH+1             registered write Gray pointer, for the read-side synchronizer

Behaviour:
- One clock (wclk). Reset is asynchronous, active-high (wrst).
- Reset values:
  - wbin=0, wptr=0, wfull=0.
  - rr_ptr=0, so requester 0 has highest priority.
  - gnt=0 and wclken=0 while wrst is high. Outputs are gated combinationally.
- Grant is combinational, same cycle:
  - If wfull=1: gnt=0.
  - Else: gnt = first set bit of req, searching from rr_ptr upward modulo NUM_REQ.
  - At most one gnt bit is set.
- Data path:
  - wdata = req_data slice of the granted requester. When no grant, wdata = slice 0 (don't-care).
  - waddr = wbin[ADDR_WIDTH-1:0].
  - The memory writes at the same edge at which gnt is seen. Zero added latency.
- On an accepting edge (|gnt):
  - wbin <= wbin+1, with natural wrap over ADDR_WIDTH+1 bits.
  - wptr <= bin2gray(wbin+1).
  - rr_ptr <= (granted index + 1) mod NUM_REQ.
- No accept: wbin, wptr and rr_ptr hold.
- Full flag:
  - wfull <= (wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
  - wgray_next is the Gray of the next binary pointer, or the current one if no accept.
  - Full therefore asserts on the edge that writes the last free slot.
  - It deasserts one edge after wq2_rptr advances.
- Boundaries:
  - Full with req pending: no grant, request stays pending, no data lost.
  - Full and wq2_rptr changing in the same cycle: no grant that cycle. The grant appears the cycle after wfull drops.
  - Address wrap 2**ADDR_WIDTH-1 -> 0 is seamless. Wrap bit wbin[ADDR_WIDTH] toggles.
  - A requester dropping req before grant is legal. Nothing is recorded.
- Reset mid-operation clears pointers, flag and rr_ptr immediately, without waiting for a clock edge. Memory contents are not cleared.
- wfull and wptr are direct register outputs, never decoded combinationally. This keeps them glitch-free for the CDC synchronizer.

Decomposition:
- Package fifo_pkg holds:
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - function bin2gray;
  - function gray2bin, shared with the read side.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs req, en, upd, wclk, wrst;
  - output one-hot gnt;
  - holds the internal rr_ptr.
- The pointer/full logic stays in the top block.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=4, NUM_REQ=4):
1. Assert wrst between edges -> wptr=5'b00000, waddr=0, wfull=0, gnt=0 immediately, before any clock edge.
2. req=4'b0100 with data 0xA5, wq2_rptr=0 -> gnt=4'b0100, wclken=1, wdata=0xA5, waddr=0; after the edge waddr=1, wptr=5'b00001.
3. req=4'b1111 held, wq2_rptr=0:
   - grants in order 0,1,2,3,0,... ;
   - after the 16th accept, wfull=1, wptr=5'b11000, gnt=0.
4. From the full state, set wq2_rptr=5'b00001 -> wfull=0 after one edge; next cycle one grant; wfull=1 again with wptr=5'b11001.
5. Reads keep pace: raise wq2_rptr so the FIFO never fills, 32 accepts -> waddr wraps 15->0 twice; wptr returns to 5'b00000; wfull never set.
6. Mid-burst (rr_ptr=2, wbin=7), pulse wrst -> all state cleared; the first grant after release goes to requester 0 when req=4'b1111.
